// File: rtl/axi_std_master.sv
// axi_std_master
// Single-outstanding AXI4 burst master. One command (read or write, INCR burst)
// is turned into AW/W/B or AR/R traffic. Write beats are streamed in through
// wr_*; read beats are streamed out through rd_*. Stream handshakes pass
// straight through to the AXI channel with no buffering.
//
// Ports
//   m00_axi_aclk / m00_axi_aresetn : clock, synchronous active-low reset
//   cmd_valid/cmd_ready, cmd_rnw, cmd_addr, cmd_len : command request (len = beats-1)
//   wr_valid/wr_ready, wr_data     : write-data stream into the W channel
//   rd_valid/rd_ready, rd_data, rd_last : read-data stream out of the R channel
//   done, done_err                 : one-cycle completion pulse and its error flag
//   m00_axi_aw*/w*/b*/ar*/r*       : AXI4 master channels
module axi_std_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_M_AXI_ADDR_WIDTH = 10,
  parameter int C_M_AXI_ID         = 0
) (
  input  logic                              m00_axi_aclk,
  input  logic                              m00_axi_aresetn,
  // command
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [7:0]                        cmd_len,
  // write stream
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     wr_data,
  // read stream
  output logic                              rd_valid,
  input  logic                              rd_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     rd_data,
  output logic                              rd_last,
  // completion
  output logic                              done,
  output logic                              done_err,
  // AW
  output logic [C_M_AXI_ID_WIDTH-1:0]       m00_axi_awid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
  output logic [7:0]                        m00_axi_awlen,
  output logic [2:0]                        m00_axi_awsize,
  output logic [1:0]                        m00_axi_awburst,
  output logic                              m00_axi_awvalid,
  input  logic                              m00_axi_awready,
  // W
  output logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
  output logic                              m00_axi_wlast,
  output logic                              m00_axi_wvalid,
  input  logic                              m00_axi_wready,
  // B
  input  logic [C_M_AXI_ID_WIDTH-1:0]       m00_axi_bid,
  input  logic [1:0]                        m00_axi_bresp,
  input  logic                              m00_axi_bvalid,
  output logic                              m00_axi_bready,
  // AR
  output logic [C_M_AXI_ID_WIDTH-1:0]       m00_axi_arid,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
  output logic [7:0]                        m00_axi_arlen,
  output logic [2:0]                        m00_axi_arsize,
  output logic [1:0]                        m00_axi_arburst,
  output logic                              m00_axi_arvalid,
  input  logic                              m00_axi_arready,
  // R
  input  logic [C_M_AXI_ID_WIDTH-1:0]       m00_axi_rid,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
  input  logic [1:0]                        m00_axi_rresp,
  input  logic                              m00_axi_rlast,
  input  logic                              m00_axi_rvalid,
  output logic                              m00_axi_rready
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_ADDR = 3'd1;
  localparam logic [2:0] WR_DATA = 3'd2;
  localparam logic [2:0] WR_RESP = 3'd3;
  localparam logic [2:0] RD_ADDR = 3'd4;
  localparam logic [2:0] RD_DATA = 3'd5;

  localparam logic [2:0] AXI_SIZE = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  localparam logic [1:0] AXI_INCR = 2'b01;
  localparam logic [C_M_AXI_ID_WIDTH-1:0] AXI_ID = C_M_AXI_ID_WIDTH'(C_M_AXI_ID);

  logic [2:0]                    state, state_n;
  logic [7:0]                    cnt, cnt_n;
  logic [7:0]                    len_q, len_n;
  logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_n;
  logic                          err, err_n;
  logic                          done_n, done_err_n;
  logic                          cmd_ready_n;
  logic                          cmd_hs, w_hs, b_hs, r_hs, last_beat;

  // Single outstanding ID, so response IDs carry no information.
  logic unused_ids;
  assign unused_ids = ^{m00_axi_bid, m00_axi_rid};

  assign cmd_hs    = cmd_valid & cmd_ready;
  assign w_hs      = (state == WR_DATA) & wr_valid & m00_axi_wready;
  assign b_hs      = (state == WR_RESP) & m00_axi_bvalid;
  assign r_hs      = (state == RD_DATA) & m00_axi_rvalid & rd_ready;
  assign last_beat = (cnt == len_q);

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    len_n      = len_q;
    addr_n     = addr_q;
    err_n      = err;
    done_n     = 1'b0;
    done_err_n = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_hs) begin
          addr_n  = cmd_addr;
          len_n   = cmd_len;
          cnt_n   = 8'd0;
          err_n   = 1'b0;
          state_n = cmd_rnw ? RD_ADDR : WR_ADDR;
        end
      end
      WR_ADDR: if (m00_axi_awready) state_n = WR_DATA;
      WR_DATA: begin
        if (w_hs) begin
          if (last_beat) state_n = WR_RESP;
          else           cnt_n   = cnt + 8'd1;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          err_n      = err | (m00_axi_bresp != 2'b00);
          done_n     = 1'b1;
          done_err_n = err_n;
          state_n    = IDLE;
        end
      end
      RD_ADDR: if (m00_axi_arready) state_n = RD_DATA;
      RD_DATA: begin
        if (r_hs) begin
          // rlast must coincide exactly with the counted final beat; an early
          // rlast flags an error but the burst still runs to the counted length.
          err_n = err | (m00_axi_rresp != 2'b00) | (m00_axi_rlast != last_beat);
          if (last_beat) begin
            done_n     = 1'b1;
            done_err_n = err_n;
            state_n    = IDLE;
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    // Held low through the done cycle so back-to-back commands get one idle cycle.
    cmd_ready_n = (state_n == IDLE) & ~done_n;
  end

  always_ff @(posedge m00_axi_aclk) begin
    if (!m00_axi_aresetn) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      len_q     <= 8'd0;
      addr_q    <= '0;
      err       <= 1'b0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      len_q     <= len_n;
      addr_q    <= addr_n;
      err       <= err_n;
      done      <= done_n;
      done_err  <= done_err_n;
      cmd_ready <= cmd_ready_n;
    end
  end

  // AW / AR: fields come from the registered command, stable while valid waits.
  assign m00_axi_awid    = AXI_ID;
  assign m00_axi_awaddr  = addr_q;
  assign m00_axi_awlen   = len_q;
  assign m00_axi_awsize  = AXI_SIZE;
  assign m00_axi_awburst = AXI_INCR;
  assign m00_axi_awvalid = (state == WR_ADDR);

  assign m00_axi_arid    = AXI_ID;
  assign m00_axi_araddr  = addr_q;
  assign m00_axi_arlen   = len_q;
  assign m00_axi_arsize  = AXI_SIZE;
  assign m00_axi_arburst = AXI_INCR;
  assign m00_axi_arvalid = (state == RD_ADDR);

  // W / B
  assign m00_axi_wdata  = wr_data;
  assign m00_axi_wstrb  = '1;
  assign m00_axi_wlast  = (state == WR_DATA) & last_beat;
  assign m00_axi_wvalid = (state == WR_DATA) & wr_valid;
  assign wr_ready       = (state == WR_DATA) & m00_axi_wready;
  assign m00_axi_bready = (state == WR_RESP);

  // R
  assign m00_axi_rready = (state == RD_DATA) & rd_ready;
  assign rd_valid       = (state == RD_DATA) & m00_axi_rvalid;
  assign rd_data        = m00_axi_rdata;
  assign rd_last        = (state == RD_DATA) & last_beat;

endmodule

// File: tb/tb_axi_std_master.sv
// tb_axi_std_master
// Directed bench for axi_std_master: the bench plays the AXI slave and the
// stream endpoints cycle by cycle and compares against hand-derived values.
module tb_axi_std_master;

  localparam int DW = 512;
  localparam int AW = 10;

  logic            clk = 1'b0;
  logic            aresetn;
  logic            cmd_valid, cmd_ready, cmd_rnw;
  logic [AW-1:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic            wr_valid, wr_ready;
  logic [DW-1:0]   wr_data;
  logic            rd_valid, rd_ready, rd_last;
  logic [DW-1:0]   rd_data;
  logic            done, done_err;
  logic [0:0]      awid, arid, bid, rid;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize;
  logic [1:0]      awburst, arburst;
  logic            awvalid, awready, arvalid, arready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [1:0]      bresp, rresp;
  logic            bvalid, bready;
  logic            rlast, rvalid, rready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axi_std_master dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .done_err(done_err),
    .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen),
    .m00_axi_awsize(awsize), .m00_axi_awburst(awburst),
    .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_arid(arid), .m00_axi_araddr(araddr), .m00_axi_arlen(arlen),
    .m00_axi_arsize(arsize), .m00_axi_arburst(arburst),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rid(rid), .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rlast(rlast), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] wpat(input int b);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = 32'hA500_0000 + 32'(b * 256 + i);
    return d;
  endfunction

  // Slave memory contents for a read beat at first address a, beat b.
  function automatic logic [DW-1:0] rpat(input logic [AW-1:0] a, input int b);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++)
      d[i*32 +: 32] = 32'h5A00_0000 + 32'((int'(a) + b * 64) * 16 + i);
    return d;
  endfunction

  task automatic issue_cmd(input logic rnw, input logic [AW-1:0] addr, input logic [7:0] len);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_rnw = rnw; cmd_addr = addr; cmd_len = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("cmd_ready_busy", cmd_ready, 1'b0);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [7:0] len, input int aw_stall,
                          input logic [1:0] resp, input logic exp_err);
    issue_cmd(1'b0, addr, len);
    wr_valid = 1'b1; wr_data = wpat(0); wready = 1'b1; awready = 1'b0;
    for (int i = 0; i < aw_stall; i++) begin
      @(negedge clk);
      chk("awvalid_wait", awvalid, 1'b1);
      chk("awaddr_stable", awaddr, addr);
      chk("no_wvalid_before_aw", wvalid, 1'b0);
      @(posedge clk); #1;
    end
    awready = 1'b1;
    @(negedge clk);
    chk("awvalid", awvalid, 1'b1);
    chk("awaddr", awaddr, addr);
    chk("awlen", awlen, len);
    chk("awsize", awsize, 3'd6);
    chk("awburst", awburst, 2'b01);
    chk("wr_ready_before_aw", wr_ready, 1'b0);
    @(posedge clk); #1;
    awready = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      wr_data = wpat(b);
      @(negedge clk);
      chk("wvalid", wvalid, 1'b1);
      chk("wr_ready", wr_ready, 1'b1);
      chk("wdata", wdata, wpat(b));
      chk("wlast", wlast, (b == int'(len)));
      if (b == 0) chk("wstrb", wstrb, {(DW/8){1'b1}});
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = resp;
    @(negedge clk);
    chk("bready", bready, 1'b1);
    chk("wvalid_after_last", wvalid, 1'b0);
    chk("done_early", done, 1'b0);
    @(posedge clk); #1;
    bvalid = 1'b0; bresp = 2'b00;
    @(negedge clk);
    chk("wr_done", done, 1'b1);
    chk("wr_done_err", done_err, exp_err);
    chk("cmd_ready_in_done", cmd_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_pulse_end", done, 1'b0);
    chk("cmd_ready_after_done", cmd_ready, 1'b1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [7:0] len, input bit toggle,
                         input int err_beat, input int rlast_beat, input logic exp_err);
    int beat = 0;
    int cyc  = 0;
    issue_cmd(1'b1, addr, len);
    rd_ready = 1'b1; arready = 1'b1;
    @(negedge clk);
    chk("arvalid", arvalid, 1'b1);
    chk("araddr", araddr, addr);
    chk("arlen", arlen, len);
    chk("arsize", arsize, 3'd6);
    chk("rready_before_ar", rready, 1'b0);
    @(posedge clk); #1;
    arready = 1'b0;
    while (beat <= int'(len) && cyc < 600) begin
      rvalid = 1'b1;
      rdata  = rpat(addr, beat);
      rlast  = (beat == rlast_beat);
      rresp  = (beat == err_beat) ? 2'b10 : 2'b00;
      @(negedge clk);
      chk("rready_mirror", rready, rd_ready);
      chk("rd_valid", rd_valid, 1'b1);
      if (rd_ready) begin
        chk("rd_data", rd_data, rpat(addr, beat));
        chk("rd_last", rd_last, (beat == int'(len)));
        beat++;
      end
      @(posedge clk); #1;
      cyc++;
      if (toggle) rd_ready = ~rd_ready;
    end
    if (cyc >= 600) chk("rd_timeout", 1'b0, 1'b1);
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; rd_ready = 1'b1;
    @(negedge clk);
    chk("rd_done", done, 1'b1);
    chk("rd_done_err", done_err, exp_err);
    chk("rready_after_done", rready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rd_done_pulse_end", done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_arvalid", arvalid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_done_err", done_err, 1'b0);
    chk("rst_awaddr", awaddr, '0);
    chk("rst_awlen", awlen, '0);
    chk("rst_bready", bready, 1'b0);
    chk("rst_rready", rready, 1'b0);
    @(posedge clk); #1;
    aresetn = 1'b1;

    // Basic write, basic single-beat read, then AW back-pressure.
    do_write(10'h040, 8'd3, 0, 2'b00, 1'b0);
    do_read(10'h080, 8'd0, 1'b0, -1, 0, 1'b0);
    do_write(10'h200, 8'd1, 5, 2'b00, 1'b0);

    // rd_ready toggling over an 8-beat read.
    do_read(10'h100, 8'd7, 1'b1, -1, 7, 1'b0);

    // Write error response, then a clean write clears it.
    do_write(10'h000, 8'd0, 0, 2'b10, 1'b1);
    do_write(10'h040, 8'd2, 1, 2'b00, 1'b0);

    // Read errors: rresp on beat 2, then an early rlast on beat 1.
    do_read(10'h140, 8'd3, 1'b0, 2, 3, 1'b1);
    do_read(10'h180, 8'd3, 1'b0, -1, 1, 1'b1);
    do_read(10'h1C0, 8'd1, 1'b0, -1, 1, 1'b0);

    // Reset in the middle of a len=7 write, at beat 2.
    issue_cmd(1'b0, 10'h300, 8'd7);
    awready = 1'b1;
    @(posedge clk); #1;
    awready = 1'b0; wr_valid = 1'b1; wready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      wr_data = wpat(b);
      @(posedge clk); #1;
    end
    wr_data = wpat(2);
    aresetn = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(negedge clk);
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_wr_ready", wr_ready, 1'b0);
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_bready", bready, 1'b0);
    chk("mid_rst_arvalid", arvalid, 1'b0);
    chk("mid_rst_rready", rready, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_awaddr", awaddr, '0);
    wr_valid = 1'b0; wready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_no_done", done, 1'b0);
    chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
    do_write(10'h0C0, 8'd1, 0, 2'b00, 1'b0);
    do_read(10'h080, 8'd2, 1'b1, -1, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
